// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin write arbiter.
// Pointer widths are derived with clog2; wdata slicing is centralised in slice_lo.
package dff_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A single requester still needs a one-bit pointer/counter.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first unmasked request at or above
// i_ptr (mod NREQ), returned one-hot with a valid flag.
import dff_arb_pkg::*;

module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic            o_valid
);

  logic [NREQ-1:0]   w_eff;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_first;
  logic [2*NREQ-1:0] w_back;

  assign w_eff = i_req & ~i_mask;

  // Rotate so that bit 0 is the ptr position, take the lowest set bit, rotate back.
  assign w_dbl = {w_eff, w_eff} >> i_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_first = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_first    = '0;
        w_first[k] = 1'b1;
      end
    end
  end

  assign w_back  = {w_first, w_first} << i_ptr;
  assign o_pick  = w_back[2*NREQ-1:NREQ];
  assign o_valid = |w_eff;

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter owning a shared WIDTH-bit register.
// Optional lock/hold feature is compiled in with ARB_LOCK_EN.
import dff_arb_pkg::*;

module dff_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
`ifdef ARB_LOCK_EN
  , parameter int MAX_HOLD = 4
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       i_lock,
`endif
  output logic [NREQ-1:0]       o_grant,
  output logic [WIDTH-1:0]      o_data_out,
  output logic                  o_busy,
  output logic                  o_dbg_state
);

  localparam int PW = ptr_width(NREQ);

  state_t           r_state;
  logic [NREQ-1:0]  r_grant;
  logic [WIDTH-1:0] r_data;
  logic [PW-1:0]    r_ptr;

  logic [NREQ-1:0]  w_mask;
  logic [NREQ-1:0]  w_pick;
  logic             w_valid;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_ptr_next;
  logic [WIDTH-1:0] w_slot [NREQ];
  logic [WIDTH-1:0] w_gdata;
  logic             w_hold;

  // The current grantee is excluded from the next decision for exactly one cycle.
  assign w_mask = (r_state == GRANT) ? r_grant : '0;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req   (i_req),
    .i_mask  (w_mask),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign w_slot[gi] = i_wdata[slice_lo(gi, WIDTH) +: WIDTH];
  end

  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_gidx  = PW'(i);
        w_gdata = w_slot[i];
      end
    end
  end

  assign w_ptr_next = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);

`ifdef ARB_LOCK_EN
  localparam int HW = ptr_width(MAX_HOLD + 1);
  logic [HW-1:0] r_hold;

  assign w_hold = (r_state == GRANT) && ((i_lock & r_grant) != '0)
                  && (int'(r_hold) < MAX_HOLD - 1);

  // Counts repeat grants to the same requester; any other outcome clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if (w_hold) begin
      r_hold <= r_hold + HW'(1);
    end else begin
      r_hold <= '0;
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      if (r_state == GRANT) begin
        r_data <= w_gdata;
        r_ptr  <= w_ptr_next;
      end
      if (w_hold) begin
        r_state <= GRANT;
      end else if (w_valid) begin
        r_state <= GRANT;
        r_grant <= w_pick;
      end else begin
        r_state <= IDLE;
        r_grant <= '0;
      end
    end
  end

  assign o_grant     = r_grant;
  assign o_data_out  = r_data;
  assign o_busy      = |r_grant;
  assign o_dbg_state = (r_state == GRANT);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter (NREQ=4, WIDTH=8); lock scenario runs
// only when ARB_LOCK_EN is defined.
module tb_dff_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  grant;
  logic [7:0]  data_out;
  logic        busy;
  logic        dbg_state;

  int total;
  int bad;

  dff_write_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_wdata     (wdata),
`ifdef ARB_LOCK_EN
    .i_lock      (lock),
`endif
    .o_grant     (grant),
    .o_data_out  (data_out),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
    wdata = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    wdata = '0;
`ifdef ARB_LOCK_EN
    lock  = 4'b0000;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    total++;
    if (busy !== 1'b0 || dbg_state !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got busy=%b state=%b want 0 0", busy, dbg_state);
    end
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (grant !== 4'b0000 || data_out !== 8'h00 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_cycle%0d: got grant=%b data=%h busy=%b want 0000 00 0",
                 k, grant, data_out, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_wdata(8'hA5, 8'h00, 8'h00, 8'h00);
    req = 4'b0001;
    tick();
    total++;
    if (grant !== 4'b0001 || busy !== 1'b1 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL single_grant: got grant=%b busy=%b data=%h want 0001 1 00", grant, busy, data_out);
    end
    req = 4'b0000;
    tick();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || data_out !== 8'hA5) begin
      bad++;
      $display("FAIL single_write: got grant=%b busy=%b data=%h want 0000 0 a5", grant, busy, data_out);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    set_wdata(8'h01, 8'h02, 8'h03, 8'h04);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (grant !== exp_g[k] || data_out !== exp_d[k]) begin
        bad++;
        $display("FAIL rotation%0d: got grant=%b data=%h want %b %h", k, grant, data_out, exp_g[k], exp_d[k]);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_mask();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    set_wdata(8'h5A, 8'h00, 8'h00, 8'h00);
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      exp_d = (k == 0) ? 8'h00 : 8'h5A;
      total++;
      if (grant !== exp_g || data_out !== exp_d || busy !== (exp_g != 4'b0000)) begin
        bad++;
        $display("FAIL mask%0d: got grant=%b data=%h busy=%b want %b %h", k, grant, data_out, busy, exp_g, exp_d);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g [4];
    logic [7:0] exp_d [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    exp_d = '{8'h00, 8'h11, 8'h22, 8'h11};
    do_reset();
    set_wdata(8'h11, 8'h22, 8'h00, 8'h00);
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (grant !== exp_g[k] || data_out !== exp_d[k]) begin
        bad++;
        $display("FAIL b2b%0d: got grant=%b data=%h want %b %h", k, grant, data_out, exp_g[k], exp_d[k]);
      end
    end
    // Requester 1 withdraws while granted; its registered grant still writes.
    req = 4'b0000;
    set_wdata(8'h11, 8'h77, 8'h00, 8'h00);
    tick();
    total++;
    if (grant !== 4'b0000 || data_out !== 8'h77) begin
      bad++;
      $display("FAIL req_drop: got grant=%b data=%h want 0000 77", grant, data_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_wdata(8'h00, 8'h00, 8'h33, 8'h00);
    req = 4'b0100;
    tick();
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL mid_first: got %b want 0100", grant); end
    tick();
    total++;
    if (grant !== 4'b0000 || data_out !== 8'h33) begin
      bad++; $display("FAIL mid_write: got grant=%b data=%h want 0000 33", grant, data_out);
    end
    tick();
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL mid_regrant: got %b want 0100", grant); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0000 || data_out !== 8'h00 || busy !== 1'b0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: got grant=%b data=%h busy=%b state=%b want 0000 00 0 0",
               grant, data_out, busy, dbg_state);
    end
    rst_n = 1'b1;
    req = 4'b1001;
    tick();
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL mid_ptr: got %b want 0001", grant); end
    req = 4'b0000;
    tick();
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    set_wdata(8'hC0, 8'hC1, 8'h00, 8'h00);
    req  = 4'b0011;
    lock = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (grant !== exp_g[k]) begin
        bad++;
        $display("FAIL lock%0d: got grant=%b want %b", k, grant, exp_g[k]);
      end
    end
    req  = 4'b0000;
    lock = 4'b0000;
    tick();
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    wdata = '0;
`ifdef ARB_LOCK_EN
    lock  = 4'b0000;
`endif
    test_reset();
    test_single();
    test_rotation();
    test_mask();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter for a shared WIDTH-bit register built from D flip-flops. Up to NREQ requesters compete to load the register. The arbiter grants one requester per cycle, captures its data, and rotates priority so that no requester starves. It sits between the requester logic and the shared storage and owns that storage.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: width of the shared register
- MAX_HOLD, 4: maximum consecutive grant cycles for one requester under lock (ARB_LOCK_EN only), ≥1
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request, level
- wdata  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- lock  in  NREQ  per-requester hold request; port exists only with ARB_LOCK_EN
- grant  out  NREQ  registered one-hot grant; also serves as the write acknowledge
- data_out  out  WIDTH  shared register contents
- busy  out  1  high while in GRANT state

## Operation
- States: IDLE and GRANT.
- IDLE:
  - If no req is high, stay in IDLE with grant = 0.
  - Otherwise pick the first requester with req high, searching from ptr upward mod NREQ. Register its one-hot grant and go to GRANT.
- GRANT, with grantee g:
  - At the clock edge ending the cycle, data_out <= wdata[g] and ptr <= (g+1) mod NREQ.
  - Next grant is chosen in the same cycle from req with bit g masked. This allows back-to-back grants to other requesters.
  - If no unmasked req is high, return to IDLE.
- Requester protocol:
  - A requester sees grant[g] high for one cycle; that is its acknowledge.
  - It deasserts req in the following cycle unless it wants another write.
  - The mask lasts one cycle only, so req[g] held high is re-granted at the earliest after one other decision.
- Masking rule: a requester is never granted in two consecutive cycles, except under lock.
- ptr width is clog2(NREQ). It wraps NREQ-1 -> 0.

## Timing
- Reset values: grant = 0, data_out = 0, busy = 0, ptr = 0, hold count = 0, state = IDLE.
- Reset mid-GRANT: the pending write is abandoned and all outputs return to reset values immediately (asynchronous).
- Latency:
  - req rises in cycle n while IDLE -> grant in cycle n+1 -> new data_out visible in cycle n+2.
  - Sustained throughput is one write per cycle when at least two requesters are active.
- Simultaneous requests: resolved strictly by rotating priority from ptr; no fixed priority.
- req dropping while granted is ignored: a grant already registered completes its write.
- busy equals OR-reduce of grant.

## Configuration
- Macro: ARB_LOCK_EN.
- With ARB_LOCK_EN:
  - If lock[g] is high during a GRANT cycle and hold count < MAX_HOLD-1, grant[g] stays high next cycle and writes again.
  - The hold counter increments on each such hold and clears whenever the grantee changes or the arbiter returns to IDLE.
  - When the limit is reached, the grant is released, g is masked, and ptr advances as normal.
- Without ARB_LOCK_EN: the lock port and hold counter are absent, and every grant lasts exactly one cycle.

## Structure
- Package dff_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the ptr width constant, derived via clog2 of NREQ;
  - the per-requester slice helper function for wdata.
- Sub-module rr_pick: combinational rotating-priority encoder. Inputs are the request vector, mask, and ptr; outputs are the one-hot pick and a valid flag. It is instantiated once.

## Test plan
- Reset then idle: reset low at t=0, release, req = 0 for 10 cycles -> grant = 0, data_out = 0, busy = 0 throughout.
- Single request: req = 0001, wdata[0] = 8'hA5 at cycle n -> grant = 0001 in n+1, data_out = A5 in n+2, busy falls in n+2.
- Rotation: req = 1111 held, wdata[i] = i+1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with no gaps and data_out following 1, 2, 3, 4.
- Mask: req = 0001 held continuously -> grant alternates 0001 and 0000, so each write is separated by one IDLE cycle.
- Reset mid-grant: reset asserted in the GRANT cycle for requester 2 -> grant and data_out clear immediately, and the next request after release is arbitrated from ptr = 0.
- Lock (ARB_LOCK_EN, MAX_HOLD = 4): req = 0011, lock = 0001 -> grant[0] is high for 4 consecutive cycles, then grant = 0010.
